// File: rtl/gpio_debounce.sv
// GPIO pad conditioner: 2-flop sync, tick-based stability filter, bypass.
// Optional registered change pulses on gpio_event: GPIO_DEBOUNCE_EVENT_EN.
module gpio_debounce #(
  parameter int unsigned          ninputs     = 16,
  parameter int unsigned          prescale    = 50000,
  parameter int unsigned          nstable     = 4,
  parameter logic [ninputs-1:0]   reset_value = '0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [ninputs-1:0] pad_inputs,
  input  logic [ninputs-1:0] bypass,
  output logic [ninputs-1:0] gpio_inputs,
  output logic [ninputs-1:0] gpio_event
);

  localparam logic [15:0] PC_LAST  = 16'(prescale - 1);
  localparam logic [3:0]  CNT_LAST = 4'(nstable - 1);

  logic [ninputs-1:0] r_s0;
  logic [ninputs-1:0] r_s1;
  logic [ninputs-1:0] r_out;
  logic [15:0]        r_pc;
  logic [3:0]         r_cnt [ninputs];

  logic               w_tick;
  logic [ninputs-1:0] w_out_nxt;
  logic [3:0]         w_cnt_nxt [ninputs];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s0 <= reset_value;
      r_s1 <= reset_value;
    end else begin
      r_s0 <= pad_inputs;
      r_s1 <= r_s0;
    end
  end

  assign w_tick = (r_pc == PC_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pc <= '0;
    end else if (w_tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 16'd1;
    end
  end

  // A matching tick restarts qualification; only unbroken mismatch runs commit.
  always_comb begin
    w_out_nxt = r_out;
    for (int i = 0; i < int'(ninputs); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (bypass[i]) begin
        w_out_nxt[i] = r_s1[i];
        w_cnt_nxt[i] = '0;
      end else if (!w_tick) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (r_s1[i] == r_out[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_out_nxt[i] = r_s1[i];
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_out <= reset_value;
      for (int i = 0; i < int'(ninputs); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_out <= w_out_nxt;
      for (int i = 0; i < int'(ninputs); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign gpio_inputs = r_out;

`ifdef GPIO_DEBOUNCE_EVENT_EN
  logic [ninputs-1:0] r_prev;
  logic [ninputs-1:0] r_event;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prev  <= reset_value;
      r_event <= '0;
    end else begin
      r_prev  <= r_out;
      r_event <= r_out ^ r_prev;
    end
  end

  assign gpio_event = r_event;
`else
  assign gpio_event = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed scenarios plus random pads/bypass,
// checked every cycle against a tick-history model.
module tb_gpio_debounce;

  localparam int P = 4;
  localparam int N = 3;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pad;
  logic [W-1:0] byp;
  logic [W-1:0] gin;
  logic [W-1:0] gev;

  int checks;
  int errors;
  bit cmp_en;

  gpio_debounce #(
    .ninputs     (W),
    .prescale    (P),
    .nstable     (N),
    .reset_value (16'h0000)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .pad_inputs  (pad),
    .bypass      (byp),
    .gpio_inputs (gin),
    .gpio_event  (gev)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: pad delay line, cycle count since reset for tick phase,
  // and per-channel history of mismatch flags at ticks since last commit.
  logic [W-1:0] m_q0, m_q1, m_out, m_ev, m_chg;
  int           m_cyc;
  logic [31:0]  m_hist [W];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] nout;
    logic [31:0]  nh;
    bit           tk;
    if (!rst_n) begin
      m_q0  <= '0;
      m_q1  <= '0;
      m_out <= '0;
      m_ev  <= '0;
      m_chg <= '0;
      m_cyc <= 0;
      for (int i = 0; i < W; i++) m_hist[i] <= '0;
    end else begin
      tk   = (m_cyc % P) == P - 1;
      nout = m_out;
      for (int i = 0; i < W; i++) begin
        nh = m_hist[i];
        if (byp[i]) begin
          nout[i] = m_q1[i];
          nh      = '0;
        end else if (tk) begin
          nh = {nh[30:0], m_q1[i] != m_out[i]};
          if (nh[N-1:0] == {N{1'b1}}) begin
            nout[i] = m_q1[i];
            nh      = '0;
          end
        end
        m_hist[i] <= nh;
      end
      m_ev  <= m_chg;
      m_chg <= nout ^ m_out;
      m_out <= nout;
      m_q1  <= m_q0;
      m_q0  <= pad;
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int n, input int lo,
                         input int hi);
    checks++;
    if (n < lo || n > hi) begin
      errors++;
      $display("FAIL %s got=%0d cycles expected %0d..%0d", name, n, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gpio_inputs", gin, m_out);
`ifdef GPIO_DEBOUNCE_EVENT_EN
      chk("model_gpio_event", gev, m_ev);
`else
      chk("event_tied_low", gev, '0);
`endif
    end
  end

  task automatic wait_bit(input int idx, input logic v, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (gin[idx] == v) return;
    end
    n = 999;
  endtask

  task automatic do_reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  int n;
  int evc;
  bit bad;

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    pad    = 16'hFFFF;
    byp    = '0;
    #1;
    cmp_en = 1'b1;
    chk("reset_inputs", gin, 16'h0000);
    chk("reset_event", gev, 16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_held", gin, 16'h0000);
    #2 rst_n = 1'b1;
    wait_bit(0, 1'b1, n);
    chk_rng("release_qualify", n, 11, 15);
    chk("release_value", gin, 16'hFFFF);

    @(negedge clk);
    pad = '0;
    wait_bit(0, 1'b0, n);
    chk_rng("all_fall", n, 11, 15);
    repeat (4) @(negedge clk);

    // clean step on channel 3
    pad[3] = 1'b1;
    wait_bit(3, 1'b1, n);
    chk_rng("step3_latency", n, 11, 15);
`ifdef GPIO_DEBOUNCE_EVENT_EN
    chk("step3_ev_pre", W'(gev[3]), W'(0));
    @(negedge clk);
    chk("step3_ev_pulse", W'(gev[3]), W'(1));
    @(negedge clk);
    chk("step3_ev_post", W'(gev[3]), W'(0));
`endif
    repeat (3) @(negedge clk);

    // bounce on channel 5: three ticks always see both levels
    evc = 0;
    bad = 1'b0;
    for (int k = 0; k < 13; k++) begin
      pad[5] = ~pad[5];
      repeat (3) begin
        @(negedge clk);
        if (gin[5]) bad = 1'b1;
        if (gev[5]) evc++;
      end
    end
    chk("bounce_no_change", W'(bad), W'(0));
    pad[5] = 1'b1;
    n = 999;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (gev[5]) evc++;
      if (gin[5] && n == 999) n = k - 3;
    end
    chk_rng("bounce_settle", n, 1, 15);
`ifdef GPIO_DEBOUNCE_EVENT_EN
    chk("bounce_one_event", W'(evc), W'(1));
`endif

    // glitch on channel 7
    @(negedge clk);
    pad[7] = 1'b1;
    repeat (2) @(negedge clk);
    pad[7] = 1'b0;
    bad = 1'b0;
    evc = 0;
    repeat (20) begin
      @(negedge clk);
      if (gin[7]) bad = 1'b1;
      if (gev[7]) evc++;
    end
    chk("glitch_rejected", W'(bad), W'(0));
    chk("glitch_no_event", W'(evc), W'(0));

    // bypass on channel 1
    byp[1] = 1'b1;
    repeat (2) @(negedge clk);
    pad[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("bypass_2cyc", W'(gin[1]), W'(0));
    @(negedge clk);
    chk("bypass_3cyc", W'(gin[1]), W'(1));
    byp[1] = 1'b0;
    pad[1] = 1'b0;
    wait_bit(1, 1'b0, n);
    chk_rng("unbypass_filter", n, 11, 15);

    // mid-qualification reset
    @(negedge clk);
    pad[9] = 1'b1;
    wait_bit(9, 1'b1, n);
    chk_rng("ch9_rise", n, 11, 15);
    pad[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("midq_pending", W'(gin[2]), W'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("midq_async_clear", gin, 16'h0000);
    chk("midq_event_clear", gev, 16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_bit(2, 1'b1, n);
    chk_rng("midq_requalify", n, 11, 15);

    // random phase
    for (int seg = 0; seg < 40; seg++) begin
      int thr;
      thr = $urandom_range(1, 60);
      @(negedge clk);
      byp = $urandom & $urandom & $urandom;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, 999) < thr) pad[i] = ~pad[i];
      end
      if (seg % 13 == 12) do_reset_pulse();
    end
    byp = '0;
    repeat (40) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
